same_label_bus_arb: RTL
=======================

Name: same_label_bus_arb

Overview:
- Two-requester round-robin arbiter sharing the 16-byte same_label_reg register block (four 32-bit words at 0x0/0x4/0x8/0xC) over its internal wr_req/wr_ack, rd_req/rd_ack bus.
- Serialises accesses, rejects writes to the read-only preset register NO_FIELDS (0x0), and bounds each downstream access with a timeout.
- Sits between two local masters (e.g. CPU bridge and hardware sequencer) and the generated register bank.

Parameters:
- ADDR_WIDTH, 4, byte address width; matches SAME_LABEL_REG_SIZE = 16.
- DATA_WIDTH, 32, data bus width.
- TIMEOUT, 16, max cycles to wait for a downstream ack; legal range 2..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- m_req_i  in  2  per-requester access request; held until its m_ack_o
- m_we_i  in  2  per-requester 1=write, 0=read
- m_adr_i  in  2*ADDR_WIDTH  per-requester byte address; bits [1:0] ignored
- m_dat_i  in  2*DATA_WIDTH  per-requester write data
- m_ack_o  out  2  one-cycle completion pulse to the granted requester
- m_err_o  out  2  asserted with m_ack_o on a rejected or timed-out access
- m_dat_o  out  DATA_WIDTH  read data, valid while m_ack_o is high; shared by both requesters
- adr_o  out  ADDR_WIDTH  downstream address, held stable from ISSUE through WAIT
- dat_o  out  DATA_WIDTH  downstream write data
- wr_req_o  out  1  downstream write strobe, one-cycle pulse
- rd_req_o  out  1  downstream read strobe, one-cycle pulse
- wr_ack_i  in  1  downstream write acknowledge
- rd_ack_i  in  1  downstream read acknowledge
- dat_i  in  DATA_WIDTH  downstream read data, valid with rd_ack_i
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, last_grant=1 so requester 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request is active, stay.
  - If exactly one request is active, grant it.
  - If both are active, grant the requester that is not last_grant.
  - On grant, latch adr, we and wdat of the winner.
  - A write whose word address is ADDR_SAME_LABEL_REG_NO_FIELDS goes to RESP with err=1 and issues nothing downstream.
  - Otherwise go to ISSUE.
- ISSUE:
  - Pulse wr_req_o or rd_req_o for exactly one cycle, load counter=0, go to WAIT.
  - An ack in this same cycle, including a combinational downstream ack, is accepted: go straight to RESP.
- WAIT:
  - Accept the ack that matches the access type; the other ack is ignored.
  - On a read ack, capture dat_i and go to RESP with err=0.
  - When the counter reaches TIMEOUT-1 with no ack, go to RESP with err=1 and read data 0.
  - Otherwise increment the counter.
- RESP:
  - Drive m_ack_o[g]=1 and m_err_o[g]=err for one cycle; m_dat_o holds the captured data.
  - Set last_grant=g, return to IDLE.
  - m_dat_o is 0 for writes.
- Latency with zero-wait downstream: m_ack_o arrives 2 cycles after the request is sampled in IDLE.
- A rejected write returns m_ack_o 1 cycle after sampling.
- Each downstream access has a worst-case latency of TIMEOUT+2 cycles.
- Boundary rules:
  - Deasserting m_req_i mid-transaction does not abort it; the ack and err pulse is still issued.
  - A requester still asserting req in the cycle after its ack is treated as a new request.
  - The losing requester is served next if it is still requesting, so neither requester starves.
  - Stray acks in IDLE, RESP or an access-type mismatch are ignored.
  - Late acks after a timeout are ignored.
  - Misaligned addresses are word-aligned silently and do not raise err.
  - Reset mid-operation aborts immediately with no pulse on any output.

Decomposition:
- Package same_label_arb_pkg holds:
  - the state enum typedef;
  - ADDR_SAME_LABEL_REG_* and SAME_LABEL_REG_SIZE, re-exported from the same_label_reg constants package;
  - the read-only address mask.
- One sub-module, same_label_rr_pick: a purely combinational 2-way round-robin picker taking req[1:0] and last_grant, returning a valid grant and its index.

Test Plan:
- Reset, then requester 0 reads 0x0 with downstream returning 0x20 combinationally -> rd_req_o pulses once, m_ack_o=01 two cycles after the request, m_dat_o=0x20, m_err_o=00.
- Requester 1 writes 0xFFF to 0x8 -> adr_o=0x8, dat_o=0xFFF, one wr_req_o pulse, m_ack_o=10, err=0; a read of 0x8 then returns 0xFFF.
- Requester 0 writes 0x0 -> no wr_req_o, m_ack_o=01 with m_err_o=01 one cycle after sampling.
- Both requesters held high continuously for 4 accesses -> grant order is 0,1,0,1.
- Read of 0xC with no ack and TIMEOUT=16 -> m_err_o pulses 17 cycles after ISSUE with m_dat_o=0; a late rd_ack_i is ignored.
- rst_i asserted during WAIT -> all outputs 0 asynchronously, no ack pulse; the next contention is granted to requester 0.

Source files
------------

// File: rtl/same_label_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : same_label_arb_pkg
// Description : Shared types and constants for the same_label_reg bus
//               arbiter. Holds the arbiter state encoding, the register map
//               of the same_label_reg block and its read-only word mask.
// Revision    : 1.0 - initial release
// ============================================================================
package same_label_arb_pkg;

    // Register map of the 16-byte same_label_reg block.
    localparam int unsigned SAME_LABEL_REG_SIZE = 16;
    localparam logic [3:0] ADDR_SAME_LABEL_REG_NO_FIELDS = 4'h0;
    localparam logic [3:0] ADDR_SAME_LABEL_REG_FIELD_A   = 4'h4;
    localparam logic [3:0] ADDR_SAME_LABEL_REG_FIELD_B   = 4'h8;
    localparam logic [3:0] ADDR_SAME_LABEL_REG_FIELD_C   = 4'hC;

    // One bit per word; a set bit marks a word that rejects writes.
    localparam logic [3:0] SAME_LABEL_REG_RO_MASK =
        4'b0001 << ADDR_SAME_LABEL_REG_NO_FIELDS[3:2];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/same_label_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : same_label_rr_pick
// Description : Combinational two-way round-robin picker. On contention the
//               requester that was not granted last wins.
// Ports       : i_req[1:0]   - request vector
//               i_last_grant - index of the most recently served requester
//               o_valid      - at least one request present
//               o_idx        - index of the winning requester
// Revision    : 1.0 - initial release
// ============================================================================
module same_label_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_idx
);

    assign o_valid = |i_req;

    always_comb begin
        o_idx = 1'b0;
        if (i_req == 2'b11) begin
            o_idx = ~i_last_grant;
        end else if (i_req[1]) begin
            o_idx = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/same_label_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : same_label_bus_arb
// Description : Round-robin arbiter letting two local masters share the
//               same_label_reg register block. Serialises accesses, rejects
//               writes to the read-only NO_FIELDS word and bounds every
//               downstream access with a timeout.
// Ports       : clk_i, rst_i          - clock, async active-high reset
//               m_req_i/m_we_i        - per-requester request / write enable
//               m_adr_i/m_dat_i       - per-requester address / write data
//               m_ack_o/m_err_o       - per-requester completion / error pulse
//               m_dat_o               - shared read data, valid with m_ack_o
//               adr_o/dat_o           - downstream address / write data
//               wr_req_o/rd_req_o     - downstream one-cycle strobes
//               wr_ack_i/rd_ack_i     - downstream acknowledges
//               dat_i                 - downstream read data
//               busy_o                - arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module same_label_bus_arb
    import same_label_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              m_req_i,
    input  logic [1:0]              m_we_i,
    input  logic [2*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [2*DATA_WIDTH-1:0] m_dat_i,
    output logic [1:0]              m_ack_o,
    output logic [1:0]              m_err_o,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    wr_req_o,
    output logic                    rd_req_o,
    input  logic                    wr_ack_i,
    input  logic                    rd_ack_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic                    busy_o
);

    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(3);
    localparam logic [7:0]            c_cnt_last   = 8'(TIMEOUT - 1);

    arb_state_t r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_we;
    logic [7:0] r_cnt;

    logic                  w_pick_valid;
    logic                  w_pick_idx;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_adr_aligned;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic                  w_is_ro;
    logic                  w_ack_match;

    same_label_rr_pick u_pick (
        .i_req        (m_req_i),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    // Winner's request fields; low address bits are dropped silently.
    assign w_we          = m_we_i[w_pick_idx];
    assign w_adr_aligned = m_adr_i[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH] & c_align_mask;
    assign w_wdat        = m_dat_i[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_is_ro       = SAME_LABEL_REG_RO_MASK[w_adr_aligned[3:2]];

    // Only the acknowledge matching the latched access type counts.
    assign w_ack_match = r_we ? wr_ack_i : rd_ack_i;

    assign busy_o = (r_state != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_cnt        <= 8'd0;
            adr_o        <= '0;
            dat_o        <= '0;
            wr_req_o     <= 1'b0;
            rd_req_o     <= 1'b0;
            m_ack_o      <= 2'b00;
            m_err_o      <= 2'b00;
            m_dat_o      <= '0;
        end else begin
            // Strobes and completion pulses are single-cycle by default.
            wr_req_o <= 1'b0;
            rd_req_o <= 1'b0;
            m_ack_o  <= 2'b00;
            m_err_o  <= 2'b00;

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_we    <= w_we;
                        adr_o   <= w_adr_aligned;
                        dat_o   <= w_wdat;
                        if (w_we && w_is_ro) begin
                            // Rejected write: answer directly, nothing goes downstream.
                            r_state             <= ST_RESP;
                            m_ack_o[w_pick_idx] <= 1'b1;
                            m_err_o[w_pick_idx] <= 1'b1;
                            m_dat_o             <= '0;
                        end else begin
                            r_state  <= ST_ISSUE;
                            wr_req_o <= w_we;
                            rd_req_o <= ~w_we;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_cnt <= 8'd0;
                    // A same-cycle (possibly combinational) ack completes at once.
                    if (w_ack_match) begin
                        r_state          <= ST_RESP;
                        m_ack_o[r_grant] <= 1'b1;
                        m_dat_o          <= r_we ? '0 : dat_i;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (w_ack_match) begin
                        r_state          <= ST_RESP;
                        m_ack_o[r_grant] <= 1'b1;
                        m_dat_o          <= r_we ? '0 : dat_i;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state          <= ST_RESP;
                        m_ack_o[r_grant] <= 1'b1;
                        m_err_o[r_grant] <= 1'b1;
                        m_dat_o          <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                    m_dat_o      <= '0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
